// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state type
// and address-field width helpers derived from the cache geometry.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  function automatic int unsigned offset_w(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int unsigned index_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_width,
                                        input int unsigned line_words,
                                        input int unsigned lines);
    return addr_width - offset_w(line_words) - index_w(lines);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Instruction word storage: LINES*LINE_WORDS x 32, asynchronous read port and
// synchronous single-word write port.
module icache_data_array #(
  parameter  int unsigned LINE_WORDS = 4,
  parameter  int unsigned LINES      = 64,
  localparam int unsigned AW         = $clog2(LINES * LINE_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [LINES*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with burst line refill and flush.
// Optional ICACHE_STATS_EN adds hit_cnt/miss_cnt counter outputs.
module inst_cache
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LINES      = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_ren,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [31:0]           inst_data,
  output logic                  inst_stall,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int unsigned WORD_W   = $clog2(LINE_WORDS);
  localparam int unsigned OFFSET_W = offset_w(LINE_WORDS);
  localparam int unsigned INDEX_W  = index_w(LINES);
  localparam int unsigned TAG_W    = tag_w(ADDR_WIDTH, LINE_WORDS, LINES);

  state_t                  r_state;
  logic [LINES-1:0]        r_valid;
  logic [TAG_W-1:0]        r_tags [LINES];
  logic [WORD_W-1:0]       r_cnt;
  logic                    r_discard;
  logic                    r_mem_req;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;

  logic [WORD_W-1:0]       w_word;
  logic [INDEX_W-1:0]      w_index;
  logic [TAG_W-1:0]        w_tag;
  logic [INDEX_W-1:0]      w_fill_index;
  logic                    w_hit;
  logic                    w_beat;
  logic                    w_last;
  logic [31:0]             w_rdata;
  logic                    w_unused;

  assign w_word       = inst_addr[OFFSET_W-1:2];
  assign w_index      = inst_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign w_tag        = inst_addr[ADDR_WIDTH-1:OFFSET_W+INDEX_W];
  assign w_unused     = ^inst_addr[1:0];
  // The latched burst base already carries the refill index and tag.
  assign w_fill_index = r_mem_addr[OFFSET_W+INDEX_W-1:OFFSET_W];

  assign w_hit  = inst_ren & r_valid[w_index] & (r_tags[w_index] == w_tag)
                & (r_state == IDLE);
  assign w_beat = (r_state == REFILL) & mem_rvalid;
  assign w_last = w_beat & (r_cnt == WORD_W'(LINE_WORDS - 1));

  assign inst_data  = w_hit ? w_rdata : '0;
  // Stall is forced low while rst is held so reset outputs do not depend on IF.
  assign inst_stall = inst_ren & ~w_hit & ~rst;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

  icache_data_array #(
    .LINE_WORDS (LINE_WORDS),
    .LINES      (LINES)
  ) u_data (
    .clk     (clk),
    .i_we    (w_beat),
    .i_waddr ({w_fill_index, r_cnt}),
    .i_wdata (mem_rdata),
    .i_raddr ({w_index, w_word}),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_cnt      <= '0;
      r_discard  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      if (flush) r_valid <= '0;
      case (r_state)
        IDLE: begin
          if (inst_ren && !w_hit) begin
            r_state    <= REFILL;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {inst_addr[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
            r_cnt      <= '0;
            r_discard  <= 1'b0;
          end
        end
        REFILL: begin
          if (flush) r_discard <= 1'b1;
          if (w_beat) r_cnt <= r_cnt + WORD_W'(1);
          // Overrides the flush clear above for this one bit; a flush now still discards.
          if (w_last) begin
            r_valid[w_fill_index] <= ~(r_discard | flush);
            r_state               <= IDLE;
            r_mem_req             <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_last) r_tags[w_fill_index] <= r_mem_addr[ADDR_WIDTH-1:OFFSET_W+INDEX_W];
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      hit_cnt <= hit_cnt + 32'(w_hit);
      if (r_state == IDLE && inst_ren && !w_hit) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Randomized self-checking bench for inst_cache against a line-level cache model
// and a burst memory model with optional wait states and stray beats.
module tb_inst_cache;

  localparam int unsigned LW   = 4;
  localparam int unsigned NL   = 64;
  localparam int          LAT0 = LW + 1;
  localparam int          LATW = 2 * LW + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_ren = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  always #5 clk = ~clk;

  inst_cache #(
    .LINE_WORDS (LW),
    .LINES      (NL),
    .ADDR_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_ren   (inst_ren),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .inst_stall (inst_stall),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned gen = 0;
  bit          wait_mode = 0;
  bit          junk = 0;
  bit          ref_valid [NL];
  logic [31:0] ref_base  [NL];
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;

  function automatic logic [31:0] memword(input logic [31:0] a, input int unsigned g);
    return (a * 32'h0100_0193) ^ (32'h5A5A_1234 + g * 32'h1111_0101);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Burst memory: beat k of a request returns the word at base+4k.
  int unsigned m_beat = 0;
  bit          m_ph = 0;
  bit          m_req_q = 0;
  bit          m_rv_q = 0;
  always @(negedge clk) begin
    if (rst) begin
      m_beat = 0; m_ph = 0; m_req_q = 0; m_rv_q = 0;
      mem_rvalid = 1'b0;
    end else begin
      if (m_req_q && m_rv_q) m_beat++;
      if (!mem_req) begin
        m_beat = 0; m_ph = 0;
        mem_rvalid = junk ? 1'($urandom % 2) : 1'b0;
        mem_rdata  = $urandom;
      end else begin
        mem_rvalid = wait_mode ? m_ph : 1'b1;
        m_ph = !m_ph;
        mem_rdata = memword(mem_addr + 32'(4 * m_beat), gen);
      end
      m_req_q = mem_req;
      m_rv_q  = mem_rvalid;
    end
  end

  task automatic model_clear();
    for (int i = 0; i < int'(NL); i++) ref_valid[i] = 0;
  endtask

  // Holds inst_ren on addr until the fetch is served; flush pulses in cycle flush_cyc.
  task automatic fetch(input logic [31:0] addr, input int flush_cyc);
    logic [31:0] base;
    int idx, lat, exp_stall, n;
    bit hit_exp, discard, done;
    base      = addr & ~32'hF;
    idx       = int'((addr >> 4) % NL);
    lat       = wait_mode ? LATW : LAT0;
    hit_exp   = ref_valid[idx] && (ref_base[idx] == base);
    discard   = !hit_exp && flush_cyc >= 1 && flush_cyc <= lat - 1;
    exp_stall = hit_exp ? 0 : (discard ? 2 * lat : lat);
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      inst_ren  = 1'b1;
      inst_addr = addr;
      flush     = (n == flush_cyc);
      #1;
      if (n == 0) begin
        check("first_stall", 32'(inst_stall), 32'(!hit_exp));
        check("detect_req", 32'(mem_req), 32'd0);
      end
      if (n == 1 && !hit_exp) check("req_cycle1", 32'(mem_req), 32'd1);
      if (mem_req) check("mem_addr", mem_addr, base);
      if (!inst_stall) done = 1;
      else begin
        n++;
        if (n > 60) begin
          check("stall_timeout", 32'(n), 32'(exp_stall));
          done = 1;
        end
      end
    end
    check("stall_cycles", 32'(n), 32'(exp_stall));
    check("hit_data", inst_data, memword(addr & ~32'h3, gen));
    check("hit_no_req", 32'(mem_req), 32'd0);
    if (flush_cyc >= 0 && flush_cyc <= n) model_clear();
    if (!hit_exp) begin
      ref_valid[idx] = 1;
      ref_base[idx]  = base;
    end
    exp_hits++;
    exp_misses += hit_exp ? 0 : (discard ? 2 : 1);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    inst_ren = 1'b0;
    flush    = 1'b0;
    inst_addr = $urandom;
    #1;
    check("idle_stall", 32'(inst_stall), 32'd0);
    check("idle_data", inst_data, 32'd0);
  endtask

  task automatic flush_idle();
    @(negedge clk);
    inst_ren = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int fc;
    model_clear();
    inst_ren  = 1'b1;
    inst_addr = 32'h40;
    #1;
    check("rst_stall", 32'(inst_stall), 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    inst_ren = 1'b0;

    // Cold miss, locality, conflict eviction
    fetch(32'h40, -1);
    fetch(32'h44, -1);
    fetch(32'h48, -1);
    fetch(32'h4C, -1);
    fetch(32'h000, -1);
    fetch(32'h400, -1);
    fetch(32'h000, -1);
    idle_cycle();

    // Wait-state memory with stray beats while idle
    wait_mode = 1; junk = 1;
    fetch(32'h208, -1);
    fetch(32'h20C, -1);
    wait_mode = 0;

    // Flush during beat 2 of a refill, then flush in an idle lookup cycle
    fetch(32'h84, 3);
    fetch(32'h80, -1);
    fetch(32'h40, -1);
    fetch(32'h44, 0);
    fetch(32'h40, -1);
    flush_idle();
    fetch(32'h48, -1);

    // Asynchronous reset after beat 1 of a refill
    flush_idle();
    @(negedge clk);
    inst_ren  = 1'b1;
    inst_addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", 32'(mem_req), 32'd0);
    check("arst_stall", 32'(inst_stall), 32'd0);
    check("arst_data", inst_data, 32'd0);
`ifdef ICACHE_STATS_EN
    check("arst_hit_cnt", hit_cnt, 32'd0);
    check("arst_miss_cnt", miss_cnt, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    inst_ren = 1'b0;
    model_clear();
    exp_hits = 0;
    exp_misses = 0;
    fetch(32'h40, -1);
    idle_cycle();
`ifdef ICACHE_STATS_EN
    check("post_rst_hit_cnt", hit_cnt, 32'd1);
    check("post_rst_miss_cnt", miss_cnt, 32'd1);
`endif

    // Randomized traffic over conflicting lines
    for (int it = 0; it < 150; it++) begin
      if ($urandom % 100 < 5) begin
        gen++;
        flush_idle();
      end else begin
        wait_mode = ($urandom % 3 == 0);
        junk      = 1'($urandom % 2);
        a  = 32'(($urandom % 4) * 1024 + ($urandom % 8) * 16 + ($urandom % 4) * 4);
        fc = -1;
        if ($urandom % 6 == 0) fc = int'($urandom % 32'(wait_mode ? LATW : LAT0));
        fetch(a, fc);
      end
    end
    idle_cycle();
`ifdef ICACHE_STATS_EN
    check("final_hit_cnt", hit_cnt, 32'(exp_hits));
    check("final_miss_cnt", miss_cnt, 32'(exp_misses));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
